// File: rtl/digit_scan_sequencer.sv
// Four-bit code sequencer for a 4-to-16 display decoder: free-running scan
// under a prescaler, or single-step advance from a debounced pushbutton.
module digit_scan_sequencer #(
    parameter int PRESCALE = 50000,
    parameter int LAST     = 15,
    parameter int BLANK    = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic step,
    input  logic dir,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic enable,
    output logic wrap
);

    localparam int            PW    = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX  = PW'(PRESCALE - 1);
    localparam logic [3:0]    LAST4 = 4'(LAST);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t        state;
    logic [3:0]    code;
    logic [PW-1:0] presc;
    logic          sync1, sync2, sync3, step_edge;

    // Returns {wrap, next code}; wrap is set when the code crosses LAST <-> 0.
    function automatic logic [4:0] next_code(input logic [3:0] cur, input logic down);
        if (down)
            return (cur == 4'd0) ? {1'b1, LAST4} : {1'b0, cur - 4'd1};
        else
            return (cur == LAST4) ? 5'b1_0000 : {1'b0, cur + 4'd1};
    endfunction

    assign {D, C, B, A} = code;

    // NOTE: every register here is assigned with <= so all flops update from
    // the same pre-edge values; a blocking = would let later lines see new state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            code      <= 4'd0;
            presc     <= '0;
            enable    <= 1'b0;
            wrap      <= 1'b0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            step_edge <= 1'b0;
        end else begin
            sync1     <= step;
            sync2     <= sync1;
            sync3     <= sync2;
            step_edge <= sync2 & ~sync3;
            wrap      <= 1'b0;

            case (state)
                IDLE: begin
                    if (run) begin
                        state  <= SCAN;
                        presc  <= '0;
                        enable <= (BLANK == 0);
                    end else if (step_edge) begin
                        state       <= HOLD;
                        {wrap, code} <= next_code(code, dir);
                        enable      <= 1'b1;
                    end else begin
                        enable <= 1'b0;
                    end
                end

                SCAN: begin
                    if (!run) begin
                        state  <= HOLD;
                        enable <= 1'b1;
                    end else if (presc == PMAX) begin
                        presc        <= '0;
                        {wrap, code} <= next_code(code, dir);
                        enable       <= (BLANK == 0);
                    end else begin
                        presc  <= presc + 1'b1;
                        // enable reflects the prescaler value being loaded now
                        enable <= (int'(presc) + 1 >= BLANK);
                    end
                end

                HOLD: begin
                    if (run) begin
                        state  <= SCAN;
                        presc  <= '0;
                        enable <= (BLANK == 0);
                    end else begin
                        enable <= 1'b1;
                        if (step_edge)
                            {wrap, code} <= next_code(code, dir);
                    end
                end

                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Scoreboard bench for digit_scan_sequencer: two instances (LAST=15, LAST=9)
// share stimulus; per-cycle expectations are queued and compared on negedge.
module tb_digit_scan_sequencer;

    logic clk, reset_n, run, step, dir;
    logic a15, b15, c15, d15, en15, wr15;
    logic a9, b9, c9, d9, en9, wr9;

    int cyc    = 0;
    int n_vec  = 0;
    int n_err  = 0;

    typedef struct {
        int         cy;
        bit         sel9;
        logic [3:0] code;
        logic       en;
        logic       wr;
    } exp_t;

    exp_t sb[$];

    digit_scan_sequencer #(.PRESCALE(4), .LAST(15), .BLANK(1)) u15 (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .dir(dir),
        .A(a15), .B(b15), .C(c15), .D(d15), .enable(en15), .wrap(wr15)
    );

    digit_scan_sequencer #(.PRESCALE(4), .LAST(9), .BLANK(1)) u9 (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .dir(dir),
        .A(a9), .B(b9), .C(c9), .D(d9), .enable(en9), .wrap(wr9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compared value is {code[3:0], enable, wrap}.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cy <= cyc) begin
            exp_t e;
            logic [5:0] got;
            e   = sb.pop_front();
            got = e.sel9 ? {d9, c9, b9, a9, en9, wr9} : {d15, c15, b15, a15, en15, wr15};
            check($sformatf("%s@%0d", e.sel9 ? "u9" : "u15", e.cy),
                  32'(got), 32'({e.code, e.en, e.wr}));
        end
    end

    task automatic push_exp(input int cy, input bit sel9, input logic [3:0] code,
                            input logic en, input logic wr);
        exp_t e;
        e.cy = cy; e.sel9 = sel9; e.code = code; e.en = en; e.wr = wr;
        sb.push_back(e);
    endtask

    // Expected scan trace after reset release at cycle n: code k occupies
    // cycles n+1+4k .. n+4+4k, enable low on the first of them.
    task automatic push_scan(input int n, input bit sel9, input int o0, input int o1,
                             input bit down, input int last);
        for (int off = o0; off <= o1; off++) begin
            int         k, c, m, km;
            logic [3:0] code;
            logic       wr;
            k    = off / 4;
            c    = off % 4;
            m    = last + 1;
            km   = k % m;
            code = down ? 4'((m - km) % m) : 4'(km);
            wr   = (c == 0) && (k > 0) && (down ? (km == 1) : (km == 0));
            push_exp(n + 1 + off, sel9, code, c != 0, wr);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two reset cycles with reset state checked on both, then release; n = release cycle.
    task automatic start_phase(input bit dir_v, input bit run_v, output int n);
        reset_n = 1'b0;
        step    = 1'b0;
        dir     = dir_v;
        run     = run_v;
        for (int i = 1; i <= 2; i++) begin
            push_exp(cyc + i, 1'b0, 4'd0, 1'b0, 1'b0);
            push_exp(cyc + i, 1'b1, 4'd0, 1'b0, 1'b0);
        end
        wait_neg(2);
        reset_n = 1'b1;
        n = cyc;
    endtask

    initial begin
        int n, m;
        reset_n = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        dir     = 1'b0;
        wait_neg(2);

        // Up-scan through all 16 codes and the wrap back to 0.
        start_phase(1'b0, 1'b1, n);
        push_scan(n, 1'b0, 0, 67, 1'b0, 15);
        wait_neg(68);

        // Down-scan with LAST=9: 0, 9, 8, ... 0, 9 with two wrap pulses.
        start_phase(1'b1, 1'b1, n);
        push_scan(n, 1'b1, 0, 47, 1'b1, 9);
        wait_neg(48);

        // Manual stepping from IDLE: three pulses give codes 1, 2, 3.
        start_phase(1'b0, 1'b0, n);
        m = n + 2;
        for (int cy = n + 1; cy <= m + 3; cy++) begin
            push_exp(cy, 1'b0, 4'd0, 1'b0, 1'b0);
            push_exp(cy, 1'b1, 4'd0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++)
            for (int cy = m + 6 * i + 4; cy <= m + 6 * i + 9; cy++) begin
                push_exp(cy, 1'b0, 4'(i + 1), 1'b1, 1'b0);
                push_exp(cy, 1'b1, 4'(i + 1), 1'b1, 1'b0);
            end
        wait_neg(2);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            wait_neg(2);
            step = 1'b0;
            wait_neg(4);
        end
        wait_neg(3);

        // Step ignored in SCAN; drop run at code 5, flip dir, one step gives 4.
        start_phase(1'b0, 1'b1, n);
        push_scan(n, 1'b0, 0, 21, 1'b0, 15);
        for (int cy = n + 23; cy <= n + 29; cy++) push_exp(cy, 1'b0, 4'd5, 1'b1, 1'b0);
        for (int cy = n + 30; cy <= n + 33; cy++) push_exp(cy, 1'b0, 4'd4, 1'b1, 1'b0);
        wait_neg(14);
        step = 1'b1;
        wait_neg(2);
        step = 1'b0;
        wait_neg(6);
        run = 1'b0;
        dir = 1'b1;
        wait_neg(4);
        step = 1'b1;
        wait_neg(2);
        step = 1'b0;
        wait_neg(5);

        // One-cycle reset at code 7 with run held high, then scan restarts.
        start_phase(1'b0, 1'b1, n);
        push_scan(n, 1'b0, 0, 29, 1'b0, 15);
        push_exp(n + 31, 1'b0, 4'd0, 1'b0, 1'b0);
        push_scan(n + 31, 1'b0, 0, 8, 1'b0, 15);
        wait_neg(30);
        reset_n = 1'b0;
        wait_neg(1);
        reset_n = 1'b1;
        wait_neg(9);

        // Step rising one cycle before reset must be discarded.
        start_phase(1'b0, 1'b0, n);
        for (int cy = n + 1; cy <= n + 16; cy++) begin
            push_exp(cy, 1'b0, 4'd0, 1'b0, 1'b0);
            push_exp(cy, 1'b1, 4'd0, 1'b0, 1'b0);
        end
        wait_neg(2);
        step = 1'b1;
        wait_neg(1);
        reset_n = 1'b0;
        step    = 1'b0;
        wait_neg(1);
        reset_n = 1'b1;
        wait_neg(14);

        for (int i = 0; i < 10 && sb.size() > 0; i++) wait_neg(1);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
